// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the IF/ID pipeline stage and the ID decode logic:
// instruction field positions, the NOP encoding, the default reset PC,
// the {pc, instr} queue entry type and the queue occupancy states.
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

    // MIPS instruction field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;

    // sll $0,$0,0 - the architectural NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default reset vector
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // One buffered instruction
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } stage_entry_t;

    // Queue occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } queue_state_t;

endpackage

// File: rtl/if_id_stage_instr_field_split.sv
// ---------------------------------------------------------------------------
// instr_field_split
// Purely combinational slicer from a 32-bit MIPS instruction word into its
// decode fields. No sign or zero extension happens here.
//   instr  in  32  instruction word
//   op     out 6   instr[31:26]
//   rs     out 5   instr[25:21]
//   rt     out 5   instr[20:16]
//   rd     out 5   instr[15:11]
//   shamt  out 5   instr[10:6]
//   funct  out 6   instr[5:0]
//   imm16  out 16  instr[15:0]
// ---------------------------------------------------------------------------
module instr_field_split
    import if_id_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign op    = instr[OP_MSB:OP_LSB];
    assign rs    = instr[RS_MSB:RS_LSB];
    assign rt    = instr[RT_MSB:RT_LSB];
    assign rd    = instr[RD_MSB:RD_LSB];
    assign shamt = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16 = instr[IMM16_MSB:IMM16_LSB];

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register built as a 2-entry skid queue. IF pushes through a
// valid/ready handshake, ID sees the head entry (or a NOP at RESET_PC when
// empty) already split into decode fields.
//
// Parameters:
//   RESET_PC  id_pc value while in reset or while the queue is empty
//   DEPTH     queue depth, only 2 is supported
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   fetch_valid/fetch_pc/fetch_instr instruction offered by IF
//   fetch_ready                      stage can accept this cycle
//   id_stall                         ID holds the head
//   flush                            discard all buffered instructions
//   id_valid/id_pc/id_instr          head entry
//   id_op/rs/rt/rd/shamt/funct/imm16 decode fields of id_instr
//   bubble_count                     ID bubble cycles (IF_ID_BUBBLE_COUNT_EN only)
//
// Optional feature macro: IF_ID_BUBBLE_COUNT_EN
// ---------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_instr,
    output logic        fetch_ready,
    input  logic        id_stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  id_op,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
`ifdef IF_ID_BUBBLE_COUNT_EN
    ,
    output logic [31:0] bubble_count
`endif
);

    // The 1-bit pointers and FULL encoding only work for two entries
    if (DEPTH != 2) begin : gDepthCheck
        $error("if_id_stage: DEPTH must be 2");
    end

    queue_state_t queueState;
    logic         rdPtr;
    logic         wrPtr;
    stage_entry_t entries [2];
    stage_entry_t headEntry;
    logic         accept;
    logic         consume;

    // Ready and valid come straight from the registered occupancy, so
    // id_stall and flush never reach fetch_ready combinationally.
    assign fetch_ready = (queueState != FULL);
    assign id_valid    = (queueState != EMPTY);
    assign accept      = fetch_valid && fetch_ready && !flush;
    assign consume     = id_valid && !id_stall && !flush;

    // Occupancy FSM and pointers. Flush wins over everything, including a
    // fetch offered in the same cycle, and returns both pointers to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queueState <= EMPTY;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
        end else if (flush) begin
            queueState <= EMPTY;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
        end else begin
            case (queueState)
                EMPTY: if (accept) queueState <= ONE;
                ONE: begin
                    if (accept && !consume)      queueState <= FULL;
                    else if (!accept && consume) queueState <= EMPTY;
                end
                FULL: if (consume) queueState <= ONE;
                default: queueState <= EMPTY;
            endcase
            if (accept)  wrPtr <= ~wrPtr;
            if (consume) rdPtr <= ~rdPtr;
        end
    end

    // Entry storage needs no reset: an entry is only read once the
    // occupancy says it was written.
    always_ff @(posedge clk) begin
        if (accept) begin
            entries[wrPtr] <= '{pc: fetch_pc, instr: fetch_instr};
        end
    end

    // Present the head, or a NOP at RESET_PC when nothing is buffered
    assign headEntry = entries[rdPtr];
    assign id_instr  = id_valid ? headEntry.instr : NOP_INSTR;
    assign id_pc     = id_valid ? headEntry.pc    : RESET_PC;

    instr_field_split uFieldSplit (
        .instr (id_instr),
        .op    (id_op),
        .rs    (id_rs),
        .rt    (id_rt),
        .rd    (id_rd),
        .shamt (id_shamt),
        .funct (id_funct),
        .imm16 (id_imm16)
    );

`ifdef IF_ID_BUBBLE_COUNT_EN
    // Count cycles in which ID receives a bubble; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= 32'd0;
        end else if (!id_valid) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Scoreboard bench for if_id_stage: accepted fetches are pushed to a queue
// of expected entries and compared against the head presented to ID.
// Honours IF_ID_BUBBLE_COUNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_if_id_stage;
    import if_id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        id_stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm16;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [31:0] bubble_count;
    logic [31:0] bubbleModel = 32'd0;
`endif

    int assertCount = 0;
    int failCount   = 0;
    stage_entry_t expQ [$];

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .id_stall    (id_stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_op       (id_op),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_imm16    (id_imm16)
`ifdef IF_ID_BUBBLE_COUNT_EN
        ,
        .bubble_count(bubble_count)
`endif
    );

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Compare every output against the scoreboard head
    task automatic compareScoreboard();
        stage_entry_t e;
        checkOutput("sb.ready", 32'(fetch_ready), 32'(expQ.size() < 2));
        if (expQ.size() == 0) begin
            checkOutput("sb.validEmpty", 32'(id_valid), 32'd0);
            checkOutput("sb.pcEmpty", id_pc, 32'h0040_0000);
            checkOutput("sb.instrEmpty", id_instr, 32'd0);
        end else begin
            e = expQ[0];
            checkOutput("sb.valid", 32'(id_valid), 32'd1);
            checkOutput("sb.pc", id_pc, e.pc);
            checkOutput("sb.instr", id_instr, e.instr);
            checkOutput("sb.op", 32'(id_op), 32'(e.instr[31:26]));
            checkOutput("sb.rs", 32'(id_rs), 32'(e.instr[25:21]));
            checkOutput("sb.rt", 32'(id_rt), 32'(e.instr[20:16]));
            checkOutput("sb.rd", 32'(id_rd), 32'(e.instr[15:11]));
            checkOutput("sb.shamt", 32'(id_shamt), 32'(e.instr[10:6]));
            checkOutput("sb.funct", 32'(id_funct), 32'(e.instr[5:0]));
            checkOutput("sb.imm16", 32'(id_imm16), 32'(e.instr[15:0]));
        end
`ifdef IF_ID_BUBBLE_COUNT_EN
        checkOutput("sb.bubbles", bubble_count, bubbleModel);
`endif
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model
    // at posedge. Reports whether the model accepted the fetch.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic stall,
                                 input logic fl, output logic accepted);
        logic modelAccept;
        logic modelConsume;
        stage_entry_t e;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = instr;
        id_stall    = stall;
        flush       = fl;
        @(negedge clk);
        compareScoreboard();
        modelAccept  = fv && (expQ.size() < 2) && !fl;
        modelConsume = (expQ.size() != 0) && !stall && !fl;
        @(posedge clk);
`ifdef IF_ID_BUBBLE_COUNT_EN
        if (expQ.size() == 0) bubbleModel++;
`endif
        if (fl) begin
            expQ.delete();
        end else begin
            if (modelConsume) void'(expQ.pop_front());
            if (modelAccept) begin
                e.pc    = pc;
                e.instr = instr;
                expQ.push_back(e);
            end
        end
        accepted = modelAccept;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        logic [31:0] stallPc [3];
        logic [31:0] stallInstr [3];
        int          idx;

        // Reset held with a fetch offered
        rst_n       = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0040_0000;
        fetch_instr = 32'h2408_FFFF;
        id_stall    = 1'b0;
        flush       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.valid", 32'(id_valid), 32'd0);
        checkOutput("reset.instr", id_instr, 32'd0);
        checkOutput("reset.pc", id_pc, 32'h0040_0000);
        checkOutput("reset.ready", 32'(fetch_ready), 32'd1);
        rst_n = 1'b1;

        // First fetch after reset
        applyStimulus(1'b1, 32'h0040_0000, 32'h2408_FFFF, 1'b0, 1'b0, acc);
        checkOutput("first.valid", 32'(id_valid), 32'd1);
        checkOutput("first.pc", id_pc, 32'h0040_0000);
        checkOutput("first.imm16", 32'(id_imm16), 32'h0000_FFFF);
        checkOutput("first.rt", 32'(id_rt), 32'd8);
        checkOutput("first.op", 32'(id_op), 32'h09);

        // Streaming: 8 back-to-back fetches, no stall
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h0040_0004 + 32'(4 * i), $urandom(), 1'b0, 1'b0, acc);
            checkOutput("stream.accept", 32'(acc), 32'd1);
        end
        repeat (2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);

        // Stall for 4 cycles while IF keeps offering, holding until accepted
        for (int i = 0; i < 3; i++) begin
            stallPc[i]    = 32'h0040_1000 + 32'(4 * i);
            stallInstr[i] = $urandom();
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, stallPc[idx], stallInstr[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("stall.ready", 32'(fetch_ready), 32'd0);
        checkOutput("stall.headPc", id_pc, 32'h0040_1000);
        checkOutput("stall.headInstr", id_instr, stallInstr[0]);
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) begin
                applyStimulus(1'b1, stallPc[idx], stallInstr[idx], 1'b0, 1'b0, acc);
                if (acc) idx++;
            end else begin
                applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
            end
        end

        // Flush while FULL with a simultaneous fetch
        applyStimulus(1'b1, 32'h0040_2000, 32'h1111_1111, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h0040_2004, 32'h2222_2222, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h0040_2008, 32'hDEAD_BEEF, 1'b1, 1'b1, acc);
        checkOutput("flush.valid", 32'(id_valid), 32'd0);
        checkOutput("flush.ready", 32'(fetch_ready), 32'd1);
        repeat (2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);

        // Field split of sll $4,$2,5
        applyStimulus(1'b1, 32'h0040_3000, 32'h0002_2140, 1'b0, 1'b0, acc);
        checkOutput("split.rs", 32'(id_rs), 32'd0);
        checkOutput("split.rt", 32'(id_rt), 32'd2);
        checkOutput("split.rd", 32'(id_rd), 32'd4);
        checkOutput("split.shamt", 32'(id_shamt), 32'd5);
        checkOutput("split.funct", 32'(id_funct), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);

        // Asynchronous reset mid-stall with the queue FULL
        applyStimulus(1'b1, 32'h0040_4000, 32'h3333_3333, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, 32'h0040_4004, 32'h4444_4444, 1'b1, 1'b0, acc);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset.valid", 32'(id_valid), 32'd0);
        checkOutput("areset.instr", id_instr, 32'd0);
        checkOutput("areset.pc", id_pc, 32'h0040_0000);
        checkOutput("areset.ready", 32'(fetch_ready), 32'd1);
`ifdef IF_ID_BUBBLE_COUNT_EN
        checkOutput("areset.bubbles", bubble_count, 32'd0);
        bubbleModel = 32'd0;
`endif
        expQ.delete();
        fetch_valid = 1'b0;
        id_stall    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
